// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encodings, parity modes and a counter sizing helper.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4,
        StBreak  = 3'd5
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // Bits needed to hold the values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, pulses wrap on the last count.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int unsigned CntW = cnt_width(CLKS_PER_BIT);
    localparam logic [CntW-1:0] Last = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] count_q, count_d;

    assign wrap = en && (count_q == Last);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = wrap ? '0 : count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: frame FSM, shift register and parity driving a registered serial line.
// Define UART_TX_BREAK_EN to add the brk_req input and the BREAK state.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
`ifdef UART_TX_BREAK_EN
    input  logic              brk_req,
`endif
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy,
    output logic [2:0]        bit_phase
);

    if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 2 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
        $fatal(1, "uart_tx_engine: illegal parameter value");
    end

    localparam int unsigned IdxW = cnt_width(DATA_W);

    uart_state_e     state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic            par_q, par_d;
    logic            tx_out_q, tx_out_d;
    logic            tmr_en, tmr_clr, tmr_wrap;
    logic            last_stop, accept, load, brk;

`ifdef UART_TX_BREAK_EN
    assign brk = brk_req;
`else
    assign brk = 1'b0;
`endif

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .reset(reset),
        .en   (tmr_en),
        .clr  (tmr_clr),
        .wrap (tmr_wrap)
    );

    assign last_stop = (state_q == StStop) && tmr_wrap && (idx_q == IdxW'(STOP_BITS - 1));
    // A pending break takes priority over a new word.
    assign tx_ready  = ((state_q == StIdle) || last_stop) && !brk;
    assign accept    = tx_valid && tx_ready;
    assign tmr_en    = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        tmr_clr = 1'b0;
        load    = 1'b0;

        case (state_q)
            StIdle: begin
                tmr_clr = 1'b1;
                if (brk) begin
                    state_d = StBreak;
                    idx_d   = '0;
                end else if (accept) begin
                    load = 1'b1;
                end
            end
            StStart: begin
                if (tmr_wrap) begin
                    state_d = StData;
                    idx_d   = '0;
                end
            end
            StData: begin
                if (tmr_wrap) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IdxW'(DATA_W - 1)) begin
                        idx_d   = '0;
                        state_d = (PARITY == PAR_NONE) ? StStop : StParity;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StParity: begin
                if (tmr_wrap) begin
                    state_d = StStop;
                    idx_d   = '0;
                end
            end
            StStop: begin
                if (last_stop) begin
                    idx_d = '0;
                    if (brk) begin
                        state_d = StBreak;
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (tmr_wrap) begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
`ifdef UART_TX_BREAK_EN
            StBreak: begin
                // idx 0: line held low while brk_req stays high; idx 1: one high stop-bit time.
                if (idx_q == '0) begin
                    tmr_clr = 1'b1;
                    if (!brk_req) begin
                        idx_d = IdxW'(1);
                    end
                end else if (tmr_wrap) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end
            end
`endif
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase

        if (load) begin
            shift_d = tx_data;
            par_d   = (^tx_data) ^ (PARITY == PAR_ODD);
            state_d = StStart;
            idx_d   = '0;
        end

        case (state_d)
            StStart:  tx_out_d = 1'b0;
            StData:   tx_out_d = shift_d[0];
            StParity: tx_out_d = par_d;
            StBreak:  tx_out_d = (idx_d != '0);
            default:  tx_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_out_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_out_q <= tx_out_d;
        end
    end

    // Reset forces the line high combinationally so an aborted frame releases the pad at once.
    assign tx_out    = tx_out_q | reset;
    assign busy      = (state_q != StIdle);
    assign bit_phase = state_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine over four parameter sets sharing one clock and reset.
module tb_uart_tx_engine;

    localparam int unsigned CPB = 16;
    localparam int unsigned DW  [4] = '{8, 8, 8, 7};
    localparam int unsigned PAR [4] = '{1, 2, 0, 0};
    localparam int unsigned STP [4] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = '0;
    logic       valid  [4];
    logic       brk    [4];
    logic       ready_w[4];
    logic       line_w [4];
    logic       busy_w [4];
    logic [2:0] phase_w[4];

    int checks = 0;
    int errors = 0;
    int cur = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        uart_tx_engine #(
            .DATA_W      (DW[gi]),
            .CLKS_PER_BIT(CPB),
            .PARITY      (PAR[gi]),
            .STOP_BITS   (STP[gi])
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
`ifdef UART_TX_BREAK_EN
            .brk_req  (brk[gi]),
`endif
            .tx_data  (tx_data[DW[gi]-1:0]),
            .tx_valid (valid[gi]),
            .tx_ready (ready_w[gi]),
            .tx_out   (line_w[gi]),
            .busy     (busy_w[gi]),
            .bit_phase(phase_w[gi])
        );
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cur++;
    endtask

    task automatic tick_to(input int c);
        while (cur < c) tick();
    endtask

    task automatic push_frame(input logic [8:0] data, input int dw, input int par, input int stops);
        logic p;
        p = (par == 2);
        exp_q.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            exp_q.push_back(data[i]);
            p ^= data[i];
        end
        if (par != 0) exp_q.push_back(p);
        for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
    endtask

    task automatic wait_ready(input int k);
        int n = 0;
        while (!ready_w[k] && n < 400) begin
            tick();
            n++;
        end
        check($sformatf("ready_wait%0d", k), ready_w[k], 1);
    endtask

    // Drives one accept; afterwards cur=0 is the first clock of the start bit.
    task automatic accept_word(input int k, input logic [7:0] data);
        wait_ready(k);
        tx_data  = data;
        valid[k] = 1'b1;
        tick();
        cur = 0;
    endtask

    task automatic check_bits(input int k, input int j0, input int j1);
        logic e;
        for (int j = j0; j <= j1; j++) begin
            tick_to(j * CPB + CPB / 2);
            if (exp_q.size() == 0) begin
                check($sformatf("sb_empty%0d_%0d", k, j), 1, 0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("bit%0d_%0d", k, j), line_w[k], e);
            end
        end
    endtask

    task automatic run_frame(input int k, input logic [7:0] data);
        int n;
        int frame;
        exp_q.delete();
        push_frame({1'b0, data}, DW[k], PAR[k], STP[k]);
        n = exp_q.size();
        frame = n * CPB;
        accept_word(k, data);
        valid[k] = 1'b0;
        check($sformatf("start_latency%0d", k), line_w[k], 0);
        check($sformatf("phase_start%0d", k), phase_w[k], 1);
        check_bits(k, 0, n - 1);
        tick_to(frame - 2);
        check($sformatf("ready_early%0d", k), ready_w[k], 0);
        tick_to(frame - 1);
        check($sformatf("ready_last%0d", k), ready_w[k], 1);
        check($sformatf("stop_last%0d", k), line_w[k], 1);
        tick_to(frame);
        check($sformatf("idle_busy%0d", k), busy_w[k], 0);
        check($sformatf("idle_line%0d", k), line_w[k], 1);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            valid[k] = 1'b0;
            brk[k]   = 1'b0;
        end
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_line%0d", k), line_w[k], 1);
            check($sformatf("rst_busy%0d", k), busy_w[k], 0);
            check($sformatf("rst_ready%0d", k), ready_w[k], 1);
            check($sformatf("rst_phase%0d", k), phase_w[k], 0);
        end
        reset = 1'b0;
        tick();

        run_frame(0, 8'hA5);
        run_frame(0, 8'h07);
        run_frame(1, 8'h07);
        run_frame(2, 8'h07);
        run_frame(3, 8'h41);

        // Back-to-back: valid held high, data changed right after the first accept.
        exp_q.delete();
        push_frame(9'h055, 8, 1, 1);
        push_frame(9'h0AA, 8, 1, 1);
        accept_word(0, 8'h55);
        tx_data = 8'hAA;
        check_bits(0, 0, 10);
        tick_to(174);
        check("b2b_ready_early", ready_w[0], 0);
        tick_to(175);
        check("b2b_ready_pulse", ready_w[0], 1);
        check("b2b_stop", line_w[0], 1);
        tick_to(176);
        valid[0] = 1'b0;
        check("b2b_start2", line_w[0], 0);
        check("b2b_ready_drop", ready_w[0], 0);
        check_bits(0, 11, 21);
        tick_to(2 * 176);
        check("b2b_idle", busy_w[0], 0);

        // Reset in the middle of data bit 3.
        accept_word(0, 8'h00);
        valid[0] = 1'b0;
        tick_to(4 * CPB + CPB / 2);
        check("mid_phase", phase_w[0], 2);
        check("mid_line", line_w[0], 0);
        reset = 1'b1;
        #1;
        check("abort_line", line_w[0], 1);
        check("abort_busy", busy_w[0], 0);
        tick();
        reset = 1'b0;
        tick();
        check("abort_ready", ready_w[0], 1);
        run_frame(0, 8'h3C);

`ifdef UART_TX_BREAK_EN
        wait_ready(0);
        brk[0]   = 1'b1;
        valid[0] = 1'b1;
        tx_data  = 8'hFF;
        tick();
        cur = 0;
        check("brk_line0", line_w[0], 0);
        check("brk_ready0", ready_w[0], 0);
        check("brk_phase", phase_w[0], 5);
        tick_to(49);
        check("brk_line49", line_w[0], 0);
        check("brk_ready49", ready_w[0], 0);
        brk[0]   = 1'b0;
        valid[0] = 1'b0;
        tick_to(50);
        check("brk_high50", line_w[0], 1);
        tick_to(65);
        check("brk_high65", line_w[0], 1);
        check("brk_ready65", ready_w[0], 0);
        tick_to(66);
        check("brk_ready66", ready_w[0], 1);
        check("brk_idle", busy_w[0], 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
